// File: rtl/maxpool_layer.sv
// rtl/maxpool_layer.sv - 2x2 stride-2 max-pooling stage for the conv_layer element stream
//
// Purpose: pools a pixel-interleaved raster stream (channel fastest, then col,
// then row) into a stream of the same format at half resolution. Elements are
// IEEE-754 bit patterns and are only compared, never modified.
//
// Ports:
//   clk           clock, all state on the rising edge
//   rst           asynchronous active-high reset
//   in_data       element value
//   in_index[3]   [0]=channel, [1]=row, [2]=col of the element
//   in_valid      element present this cycle
//   out_data      pooled maximum
//   out_index[3]  [0]=channel, [1]=row/2, [2]=col/2
//   output_valid  one-cycle pulse per pooled element
//   frame_done    pulses with the last pooled element of a frame
//   seq_error     sticky, set by any out-of-order element
module maxpool_layer #(
  parameter int DATA_SIZE    = 64,
  parameter int NUM_CHANNELS = 16,
  parameter int INPUT_DIM    = 26
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [DATA_SIZE-1:0] in_data,
  input  logic [15:0]          in_index [3],
  input  logic                 in_valid,
  output logic [DATA_SIZE-1:0] out_data,
  output logic [15:0]          out_index [3],
  output logic                 output_valid,
  output logic                 frame_done,
  output logic                 seq_error
);

  localparam int OUT_DIM  = INPUT_DIM / 2;
  localparam int RB_DEPTH = NUM_CHANNELS * OUT_DIM;
  localparam int CH_W     = (NUM_CHANNELS > 1) ? $clog2(NUM_CHANNELS) : 1;
  localparam int RB_W     = (RB_DEPTH > 1) ? $clog2(RB_DEPTH) : 1;
  localparam logic [15:0] LAST_CH  = 16'(NUM_CHANNELS - 1);
  localparam logic [15:0] LAST_POS = 16'(INPUT_DIM - 1);

  // Expected position of the next element in the raster.
  logic [15:0] exp_ch, exp_row, exp_col;

  // hold: left element of the current horizontal pair, per channel.
  // rowbuf: pair maxima of the even row, waiting for the odd row.
  logic [DATA_SIZE-1:0] hold   [NUM_CHANNELS];
  logic [DATA_SIZE-1:0] rowbuf [RB_DEPTH];

  logic            accept;
  logic            mismatch;
  logic [CH_W-1:0] hold_addr;
  logic [RB_W-1:0] rb_addr;
  logic [DATA_SIZE-1:0] pair_max;
  logic [DATA_SIZE-1:0] quad_max;
  logic            last_elem;

  // Monotonic ordering key: negatives are bit-inverted, positives get the
  // sign bit set, so -0 sorts below +0 and an unsigned compare orders values.
  function automatic logic [DATA_SIZE-1:0] order_key(input logic [DATA_SIZE-1:0] x);
    return x[DATA_SIZE-1] ? ~x : {1'b1, x[DATA_SIZE-2:0]};
  endfunction

  // Later element wins only when strictly greater, so ties keep the earlier one.
  function automatic logic [DATA_SIZE-1:0] max_of(input logic [DATA_SIZE-1:0] earlier,
                                                  input logic [DATA_SIZE-1:0] later);
    return (order_key(later) > order_key(earlier)) ? later : earlier;
  endfunction

  // Accepted elements always carry the expected index, so the counters
  // double as the element's position for addressing.
  assign accept    = in_valid && (in_index[0] == exp_ch) && (in_index[1] == exp_row)
                     && (in_index[2] == exp_col);
  assign mismatch  = in_valid && !accept;
  assign hold_addr = CH_W'(exp_ch);
  assign rb_addr   = RB_W'(32'(exp_ch) * OUT_DIM + 32'(exp_col[15:1]));
  assign pair_max  = max_of(hold[hold_addr], in_data);
  assign quad_max  = max_of(rowbuf[rb_addr], pair_max);
  assign last_elem = (exp_ch == LAST_CH) && (exp_row == LAST_POS) && (exp_col == LAST_POS);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      exp_ch       <= '0;
      exp_row      <= '0;
      exp_col      <= '0;
      out_data     <= '0;
      out_index[0] <= '0;
      out_index[1] <= '0;
      out_index[2] <= '0;
      output_valid <= 1'b0;
      frame_done   <= 1'b0;
      seq_error    <= 1'b0;
    end else begin
      output_valid <= 1'b0;
      frame_done   <= 1'b0;
      if (mismatch) begin
        seq_error <= 1'b1;
      end
      if (accept) begin
        if (exp_ch == LAST_CH) begin
          exp_ch <= '0;
          if (exp_col == LAST_POS) begin
            exp_col <= '0;
            exp_row <= (exp_row == LAST_POS) ? 16'd0 : exp_row + 16'd1;
          end else begin
            exp_col <= exp_col + 16'd1;
          end
        end else begin
          exp_ch <= exp_ch + 16'd1;
        end
        // Bottom-right element of a window completes it.
        if (exp_col[0] && exp_row[0]) begin
          out_data     <= quad_max;
          out_index[0] <= exp_ch;
          out_index[1] <= exp_row >> 1;
          out_index[2] <= exp_col >> 1;
          output_valid <= 1'b1;
          frame_done   <= last_elem;
        end
      end
    end
  end

  // Buffers are not reset: every entry is written before it is read.
  always_ff @(posedge clk) begin
    if (accept) begin
      if (!exp_col[0]) begin
        hold[hold_addr] <= in_data;
      end else if (!exp_row[0]) begin
        rowbuf[rb_addr] <= pair_max;
      end
    end
  end

endmodule

// File: tb/tb_maxpool_layer.sv
// tb/tb_maxpool_layer.sv - directed bench for maxpool_layer (small and default configurations)
module tb_maxpool_layer;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [63:0] in_data = '0;
  logic [15:0] in_index [3];
  logic        vs = 1'b0;
  logic        vb = 1'b0;

  logic [63:0] s_data, b_data;
  logic [15:0] s_index [3];
  logic [15:0] b_index [3];
  logic        s_valid, s_done, s_err;
  logic        b_valid, b_done, b_err;

  int errors = 0;
  int checks = 0;

  logic [63:0] sv [16];
  logic [63:0] se [4];
  real         bf [16][26][26];
  int          b_outs;
  int          b_dones;

  always #5 clk = ~clk;

  maxpool_layer #(.DATA_SIZE(64), .NUM_CHANNELS(1), .INPUT_DIM(4)) u_small (
    .clk(clk), .rst(rst), .in_data(in_data), .in_index(in_index), .in_valid(vs),
    .out_data(s_data), .out_index(s_index), .output_valid(s_valid),
    .frame_done(s_done), .seq_error(s_err)
  );

  maxpool_layer u_big (
    .clk(clk), .rst(rst), .in_data(in_data), .in_index(in_index), .in_valid(vb),
    .out_data(b_data), .out_index(b_index), .output_valid(b_valid),
    .frame_done(b_done), .seq_error(b_err)
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Present one element for exactly one rising edge, then sample at edge+1.
  task automatic step(input bit sel, input int ch, input int r, input int c, input logic [63:0] d);
    in_data     = d;
    in_index[0] = 16'(ch);
    in_index[1] = 16'(r);
    in_index[2] = 16'(c);
    if (sel) vb = 1'b1; else vs = 1'b1;
    @(posedge clk);
    #1;
    vs = 1'b0;
    vb = 1'b0;
  endtask

  task automatic out_check(input bit sel, input bit ev, input logic [63:0] ed, input int ec,
                           input int er, input int ecl, input bit edone, input string tag);
    logic        v, dn;
    logic [63:0] d;
    logic [47:0] idx;
    v   = sel ? b_valid : s_valid;
    dn  = sel ? b_done : s_done;
    d   = sel ? b_data : s_data;
    idx = sel ? {b_index[0], b_index[1], b_index[2]} : {s_index[0], s_index[1], s_index[2]};
    chk({tag, ".valid"}, 64'(v), 64'(ev));
    if (ev) begin
      chk({tag, ".data"}, d, ed);
      chk({tag, ".index"}, 64'(idx), {16'd0, 16'(ec), 16'(er), 16'(ecl)});
    end
    chk({tag, ".done"}, 64'(dn), 64'(edone));
  endtask

  task automatic run_small(input bit gaps, input string tag);
    for (int r = 0; r < 4; r++) begin
      for (int c = 0; c < 4; c++) begin
        bit ev;
        ev = (r % 2 == 1) && (c % 2 == 1);
        step(1'b0, 0, r, c, sv[r*4+c]);
        out_check(1'b0, ev, se[(r/2)*2 + c/2], 0, r/2, c/2, ev && r == 3 && c == 3, tag);
        if (gaps) begin
          repeat ($urandom_range(0, 3)) begin
            @(posedge clk);
            #1;
            chk({tag, ".idle"}, 64'(s_valid), 64'd0);
          end
        end
      end
    end
  endtask

  task automatic fill_big();
    for (int ch = 0; ch < 16; ch++)
      for (int r = 0; r < 26; r++)
        for (int c = 0; c < 26; c++)
          bf[ch][r][c] = real'(int'($urandom_range(0, 2000)) - 1000) / 8.0;
  endtask

  task automatic run_big(input string tag);
    int outs;
    outs = 0;
    fill_big();
    for (int r = 0; r < 26; r++) begin
      for (int c = 0; c < 26; c++) begin
        for (int ch = 0; ch < 16; ch++) begin
          bit  ev;
          real m;
          ev = (r % 2 == 1) && (c % 2 == 1);
          m  = 0.0;
          if (ev) begin
            m = bf[ch][r-1][c-1];
            if (bf[ch][r-1][c] > m) m = bf[ch][r-1][c];
            if (bf[ch][r][c-1] > m) m = bf[ch][r][c-1];
            if (bf[ch][r][c] > m) m = bf[ch][r][c];
          end
          step(1'b1, ch, r, c, $realtobits(bf[ch][r][c]));
          if (b_valid) outs++;
          if (b_done) b_dones++;
          out_check(1'b1, ev, $realtobits(m), ch, r/2, c/2,
                    ev && ch == 15 && r == 25 && c == 25, tag);
        end
      end
    end
    chk({tag, ".outs"}, 64'(outs), 64'd2704);
    b_outs += outs;
  endtask

  initial begin
    in_index[0] = '0;
    in_index[1] = '0;
    in_index[2] = '0;
    b_outs  = 0;
    b_dones = 0;

    // Reset state
    repeat (2) @(posedge clk);
    #1;
    chk("rst.s_valid", 64'(s_valid), 64'd0);
    chk("rst.s_data", s_data, 64'd0);
    chk("rst.s_index", 64'({s_index[0], s_index[1], s_index[2]}), 64'd0);
    chk("rst.s_done", 64'(s_done), 64'd0);
    chk("rst.s_err", 64'(s_err), 64'd0);
    chk("rst.b_valid", 64'(b_valid), 64'd0);
    chk("rst.b_err", 64'(b_err), 64'd0);
    rst = 1'b0;
    @(posedge clk);
    #1;

    // Single channel 1.0..16.0
    for (int i = 0; i < 16; i++) sv[i] = $realtobits(real'(i + 1));
    se[0] = 64'h4018000000000000;  // 6.0
    se[1] = 64'h4020000000000000;  // 8.0
    se[2] = 64'h402C000000000000;  // 14.0
    se[3] = 64'h4030000000000000;  // 16.0
    run_small(1'b0, "ramp");

    // Signs and zeros
    sv = '{64'hC008000000000000, 64'h8000000000000000, 64'hC014000000000000, 64'hC000000000000000,
           64'h0000000000000000, 64'hBFF0000000000000, 64'hC01C000000000000, 64'hC022000000000000,
           64'h3FF0000000000000, 64'h4000000000000000, 64'hC010000000000000, 64'hC020000000000000,
           64'h3FE0000000000000, 64'hBFF0000000000000, 64'hC008000000000000, 64'hC004000000000000};
    se[0] = 64'h0000000000000000;  // +0.0
    se[1] = 64'hC000000000000000;  // -2.0
    se[2] = 64'h4000000000000000;  // 2.0
    se[3] = 64'hC004000000000000;  // -2.5
    run_small(1'b0, "signs");

    // Idle gaps inside the ramp frame
    for (int i = 0; i < 16; i++) sv[i] = $realtobits(real'(i + 1));
    se[0] = 64'h4018000000000000;
    se[1] = 64'h4020000000000000;
    se[2] = 64'h402C000000000000;
    se[3] = 64'h4030000000000000;
    run_small(1'b1, "gaps");

    // Out-of-order element is dropped and sets the sticky flag
    step(1'b0, 3, 0, 0, 64'h4059000000000000);
    out_check(1'b0, 1'b0, 64'd0, 0, 0, 0, 1'b0, "oos");
    chk("oos.err", 64'(s_err), 64'd1);
    run_small(1'b0, "oos_resume");
    chk("oos.sticky", 64'(s_err), 64'd1);

    // Two default-size random frames back to back
    run_big("big1");
    run_big("big2");
    chk("big.dones", 64'(b_dones), 64'd2);
    chk("big.err", 64'(b_err), 64'd0);

    // Reset mid-frame clears outputs at once and leaves no residue
    fill_big();
    for (int i = 0; i < 100; i++)
      step(1'b1, i % 16, 0, i / 16, $realtobits(bf[i % 16][0][i / 16]));
    rst = 1'b1;
    #1;
    chk("mid_rst.b_data", b_data, 64'd0);
    chk("mid_rst.b_index", 64'({b_index[0], b_index[1], b_index[2]}), 64'd0);
    chk("mid_rst.b_valid", 64'(b_valid), 64'd0);
    chk("mid_rst.s_err", 64'(s_err), 64'd0);
    @(posedge clk);
    #1;
    rst = 1'b0;
    b_dones = 0;
    run_big("big3");
    chk("big3.dones", 64'(b_dones), 64'd1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/maxpool_layer.md
Name: maxpool_layer

Overview:
- 2x2, stride-2 max-pooling stage sitting directly downstream of conv_layer; consumes its out_data/out_index/output_valid stream.
- Produces a downsampled stream in the same format, so a following conv_layer or dense stage can consume it directly.
- Data are IEEE-754 doubles carried as raw DATA_SIZE-bit vectors; no arithmetic beyond comparison.
- Holds one row of partial maxima per channel; no backpressure.

Parameters:
- DATA_SIZE, 64: element width; IEEE-754 double bit pattern.
- NUM_CHANNELS, 16: channels per pixel; equals upstream NUM_OUTPUTS.
- INPUT_DIM, 26: input feature-map side (28-3+1); must be even; output side is INPUT_DIM/2.

Ports:
- clk  input  1  clock; all state on rising edge.
- rst  input  1  asynchronous, active-high reset.
- in_data  input  DATA_SIZE  element value.
- in_index  input  [15:0] x3 unpacked array  [0]=channel, [1]=row, [2]=col.
- in_valid  input  1  element present this cycle.
- out_data  output  DATA_SIZE  pooled maximum.
- out_index  output  [15:0] x3 unpacked array  [0]=channel, [1]=row/2, [2]=col/2.
- output_valid  output  1  out_data/out_index valid this cycle (single-cycle pulse per element).
- frame_done  output  1  pulses with the final pooled element of a frame.
- seq_error  output  1  sticky; an out-of-order element was received.

Behaviour:
- Reset (async, rst=1): output_valid=0, frame_done=0, seq_error=0, out_data=0, out_index all 0; expected counters (ch,row,col)=0. Buffer contents are don't-care; every entry is written before it is read.
- Input order is fixed: pixel-interleaved raster. Channel varies fastest, then col, then row.
- An accepted element is in_valid=1 with in_index equal to the expected counters. Counters then advance: ch 0..NUM_CHANNELS-1, then col++, then row++.
- Wrap: after (NUM_CHANNELS-1, INPUT_DIM-1, INPUT_DIM-1), all counters return to 0.
- Mismatch with in_valid=1:
  - seq_error is set; it is cleared only by rst.
  - The element is dropped and counters do not advance.
  - No output results from it.
- in_valid=0: no state change.
- Ordering: greater(a,b) uses key(x) = x[MSB] ? ~x : x with MSB inverted, compared as unsigned.
  - Result: -0 < +0, and negatives are ordered correctly.
  - NaN is not expected; its result is whatever the key produces.
  - Ties keep the earlier element.
- Per accepted element (ch,r,c,d):
  - c even: hold[ch] <= d.
  - c odd, r even: rowbuf[ch][c/2] <= max(hold[ch], d).
  - c odd, r odd: result = max(rowbuf[ch][c/2], max(hold[ch], d)). Register it to out_data, with out_index={ch, r/2, c/2} and output_valid=1, on the next rising edge.
- Latency: exactly 1 cycle from the accepting edge to the output_valid high cycle. Sustained throughput is one input per cycle.
- Output rate: one output per 4 accepted inputs of a channel quad. Total per frame = NUM_CHANNELS*(INPUT_DIM/2)^2, in ch-fastest, col, row order.
- frame_done=1 in the same cycle as the output for (NUM_CHANNELS-1, INPUT_DIM/2-1, INPUT_DIM/2-1); 0 otherwise.
- Back-to-back frames need no idle cycle between them.
- rowbuf: NUM_CHANNELS*(INPUT_DIM/2) entries of DATA_SIZE bits.
  - Implemented as a synchronous-write register array.
  - A read of the same entry in the same cycle as a write is not possible, because an entry is written on even rows and read on odd rows.
- Reset mid-frame: partial state is abandoned and no output is produced from it. The next accepted element must be index (0,0,0).
- out_data/out_index hold their last value when output_valid=0.

Test Plan:
- Single channel (NUM_CHANNELS=1, INPUT_DIM=4), inputs 1.0..16.0 raster -> outputs 6.0, 8.0, 14.0, 16.0 at indices (0,0,0), (0,0,1), (0,1,0), (0,1,1), each 1 cycle after its 4th contributing input; frame_done with 16.0.
- Signs and zero: window {-3.0, -0.0, +0.0, -1.0} -> +0.0 (64'h0); window {-5.0, -2.0, -7.0, -9.0} -> -2.0 (64'hC000000000000000).
- Default params, full random frame streamed back-to-back at 1 element/cycle, followed immediately by a second frame -> 2704 outputs per frame matching a software max-pool model; frame_done exactly twice; seq_error stays 0.
- Out-of-order element: index (0,0,0) expected, (3,0,0) sent -> seq_error=1 and remains set; counters unchanged; a correct (0,0,0) is then accepted and pooling continues correctly.
- Reset asserted mid-frame (after 100 inputs) -> all outputs 0 immediately (asynchronous); a new frame from (0,0,0) pools correctly with no residue from the old frame.
- in_valid gaps: random idle cycles inserted into the single-channel case -> outputs identical to the first scenario, each still exactly 1 cycle after its completing input.
